// File: rtl/piezo_note_scheduler_pkg.sv
// Shared definitions for the piezo melody scheduler: note indices, FSM states,
// ROM entry field positions and small helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package piezo_note_scheduler_pkg;

  // Note indices, one per tone-generator input (bit position in note_req)
  localparam logic [2:0] NOTE_DO    = 3'd0;
  localparam logic [2:0] NOTE_RE    = 3'd1;
  localparam logic [2:0] NOTE_MI    = 3'd2;
  localparam logic [2:0] NOTE_FA    = 3'd3;
  localparam logic [2:0] NOTE_SO    = 3'd4;
  localparam logic [2:0] NOTE_LA    = 3'd5;
  localparam logic [2:0] NOTE_TI    = 3'd6;
  localparam logic [2:0] NOTE_DO_HI = 3'd7;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ROM entry layout: {rest, note[2:0], beats[1:0]}
  localparam int ROM_W        = 6;
  localparam int ROM_REST_BIT = 5;
  localparam int ROM_NOTE_HI  = 4;
  localparam int ROM_NOTE_LO  = 2;
  localparam int ROM_BEATS_HI = 1;
  localparam int ROM_BEATS_LO = 0;

  function automatic logic [ROM_W-1:0] rom_entry(input logic rest, input logic [2:0] note,
                                                 input logic [1:0] beats);
    return {rest, note, beats};
  endfunction

  // Isolates the lowest set bit: two's complement keeps only that bit in common
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/piezo_song_rom.sv
// Fixed 16-step melody table; each entry is {rest, note[2:0], beats[1:0]}, beats==0 means 4.
// Latency: combinational. Backpressure: none.
// Ports: addr (step index) -> entry (6-bit ROM word).
module piezo_song_rom
  import piezo_note_scheduler_pkg::*;
(
  input  logic [3:0]       addr,
  output logic [ROM_W-1:0] entry
);

  always_comb begin
    entry = rom_entry(1'b1, NOTE_DO, 2'd1);
    case (addr)
      4'd0:  entry = rom_entry(1'b0, NOTE_DO,    2'd1);
      4'd1:  entry = rom_entry(1'b0, NOTE_MI,    2'd2);
      4'd2:  entry = rom_entry(1'b1, NOTE_DO,    2'd1);
      4'd3:  entry = rom_entry(1'b0, NOTE_FA,    2'd1);
      4'd4:  entry = rom_entry(1'b0, NOTE_SO,    2'd2);
      4'd5:  entry = rom_entry(1'b0, NOTE_LA,    2'd1);
      4'd6:  entry = rom_entry(1'b0, NOTE_TI,    2'd1);
      4'd7:  entry = rom_entry(1'b0, NOTE_LA,    2'd2);
      4'd8:  entry = rom_entry(1'b0, NOTE_SO,    2'd1);
      4'd9:  entry = rom_entry(1'b1, NOTE_DO,    2'd1);
      4'd10: entry = rom_entry(1'b0, NOTE_RE,    2'd1);
      4'd11: entry = rom_entry(1'b0, NOTE_MI,    2'd1);
      4'd12: entry = rom_entry(1'b0, NOTE_FA,    2'd2);
      4'd13: entry = rom_entry(1'b0, NOTE_MI,    2'd3);
      4'd14: entry = rom_entry(1'b0, NOTE_RE,    2'd1);
      4'd15: entry = rom_entry(1'b0, NOTE_DO_HI, 2'd0);
      default: entry = rom_entry(1'b1, NOTE_DO, 2'd1);
    endcase
  end

endmodule

// File: rtl/piezo_note_scheduler.sv
// Plays the ROM melody on the one-hot piezo note bus; the live keypad overrides and pauses it.
// Latency: note_req is registered, 1 cycle after start/btn is sampled.
// Backpressure: none; keypad hold freezes the melody's duration counter and state.
// Ports: clk, rst (sync, active-low), btn[7:0] keypad, start/stop pulses;
//        note_req[7:0] one-hot note, playing, step_idx[3:0], done pulse.
// Build option: define PIEZO_LOOP_EN to loop the melody until stop (done pulses per wrap).
module piezo_note_scheduler
  import piezo_note_scheduler_pkg::*;
#(
  parameter int BEAT_CYC = 250000,
  parameter int GAP_CYC  = 20000,
  parameter int SONG_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] note_req,
  output logic       playing,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int         CW        = $clog2(4 * BEAT_CYC);
  localparam logic [3:0] LAST_STEP = 4'(SONG_LEN - 1);

  state_t           state, state_n;
  logic [CW-1:0]    dur_cnt, cnt_n;
  logic [CW-1:0]    dur_last, dur_last_n;
  logic [CW-1:0]    play_last, play_last_n;
  logic [3:0]       step_n;
  logic             done_n;
  logic [7:0]       note_n;
  logic [ROM_W-1:0] ent_n;
  logic             keys_held;

  assign keys_held = |btn;
  assign playing   = (state == ST_PLAY) || (state == ST_GAP);

  // ROM is addressed by the next step so the registered note lines up with the new state;
  // the step's duration limits are registered alongside step_idx.
  piezo_song_rom u_rom (
    .addr  (step_n),
    .entry (ent_n)
  );

  always_comb begin
    dur_last_n = CW'(4 * BEAT_CYC - 1);
    case (ent_n[ROM_BEATS_HI:ROM_BEATS_LO])
      2'd1:    dur_last_n = CW'(BEAT_CYC - 1);
      2'd2:    dur_last_n = CW'(2 * BEAT_CYC - 1);
      2'd3:    dur_last_n = CW'(3 * BEAT_CYC - 1);
      default: dur_last_n = CW'(4 * BEAT_CYC - 1);
    endcase
    play_last_n = dur_last_n - CW'(GAP_CYC);
  end

  // One counter spans the whole note: PLAY covers 0..D-GAP-1, GAP covers D-GAP..D-1.
  always_comb begin
    state_n = state;
    cnt_n   = dur_cnt;
    step_n  = step_idx;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n = ST_PLAY;
          step_n  = 4'd0;
          cnt_n   = '0;
        end
      end
      ST_PLAY: begin
        if (!keys_held) begin
          cnt_n = dur_cnt + CW'(1);
          if (dur_cnt == play_last) state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!keys_held) begin
          if (dur_cnt == dur_last) begin
            cnt_n = '0;
            if (step_idx == LAST_STEP) begin
`ifdef PIEZO_LOOP_EN
              state_n = ST_PLAY;
              step_n  = 4'd0;
              done_n  = 1'b1;
`else
              state_n = ST_DONE;
              done_n  = 1'b1;
`endif
            end else begin
              state_n = ST_PLAY;
              step_n  = step_idx + 4'd1;
            end
          end else begin
            cnt_n = dur_cnt + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        step_n  = 4'd0;
      end
      default: begin
        state_n = ST_IDLE;
        step_n  = 4'd0;
      end
    endcase
    // stop overrides everything, including a simultaneous start
    if (stop && state != ST_IDLE) begin
      state_n = ST_IDLE;
      step_n  = 4'd0;
      cnt_n   = '0;
      done_n  = 1'b0;
    end
  end

  // Keypad priority encoder wins over the melody note
  always_comb begin
    note_n = 8'h00;
    if (keys_held) begin
      note_n = lowest_onehot(btn);
    end else if (state_n == ST_PLAY && !ent_n[ROM_REST_BIT]) begin
      note_n = 8'b1 << ent_n[ROM_NOTE_HI:ROM_NOTE_LO];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      dur_cnt   <= '0;
      step_idx  <= 4'd0;
      done      <= 1'b0;
      note_req  <= 8'h00;
      dur_last  <= '0;
      play_last <= '0;
    end else begin
      state     <= state_n;
      dur_cnt   <= cnt_n;
      step_idx  <= step_n;
      done      <= done_n;
      note_req  <= note_n;
      dur_last  <= dur_last_n;
      play_last <= play_last_n;
    end
  end

endmodule

// File: tb/tb_piezo_note_scheduler.sv
// Bench for piezo_note_scheduler: the melody is flattened into a per-cycle timeline with a
// cursor that only advances while no key is held; a scoreboard queue carries the expected
// outputs from the driver to a negedge monitor.
module tb_piezo_note_scheduler;

  localparam int BEAT = 100;
  localparam int GAP  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] btn = 8'h00;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] note_req;
  logic       playing;
  logic [3:0] step_idx;
  logic       done;

  piezo_note_scheduler #(
    .BEAT_CYC (BEAT),
    .GAP_CYC  (GAP),
    .SONG_LEN (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .start    (start),
    .stop     (stop),
    .note_req (note_req),
    .playing  (playing),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] note;
    logic       playing;
    logic [3:0] step;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   cyc = 0;

  // Melody as written: note index, rest flag, length in beats (1..4)
  int song_note [16] = '{0, 2, 0, 3, 4, 5, 6, 5, 4, 0, 1, 2, 3, 2, 1, 7};
  int song_rest [16] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int song_beats[16] = '{1, 2, 1, 1, 2, 1, 1, 2, 1, 1, 1, 1, 2, 3, 1, 4};

  int tl_note[$];
  int tl_step[$];

  bit m_active = 0;
  bit m_done_cyc = 0;
  int m_pos = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] low_key(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (b[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  task automatic build_timeline();
    for (int s = 0; s < 16; s++) begin
      int d;
      d = song_beats[s] * BEAT;
      for (int c = 0; c < d; c++) begin
        tl_note.push_back((c < d - GAP && song_rest[s] == 0) ? (1 << song_note[s]) : 0);
        tl_step.push_back(s);
      end
    end
  endtask

  task automatic model(input logic r, input logic [7:0] b, input logic s, input logic p);
    exp_t e;
    bit   dn;
    dn = 1'b0;
    if (!r) begin
      m_active = 0; m_pos = 0; m_done_cyc = 0;
    end else if (m_done_cyc) begin
      m_done_cyc = 0;
    end else if (m_active && p) begin
      m_active = 0;
    end else if (!m_active && s && !p) begin
      m_active = 1; m_pos = 0;
    end else if (m_active && b == 8'h00) begin
      m_pos++;
      if (m_pos == tl_note.size()) begin
`ifdef PIEZO_LOOP_EN
        m_pos = 0;
        dn = 1'b1;
`else
        m_active = 0;
        m_done_cyc = 1;
        dn = 1'b1;
`endif
      end
    end
    if (!r) e.note = 8'h00;
    else if (b != 8'h00) e.note = low_key(b);
    else e.note = m_active ? 8'(tl_note[m_pos]) : 8'h00;
    e.playing = m_active;
    e.step    = m_active ? 4'(tl_step[m_pos]) : (m_done_cyc ? 4'd15 : 4'd0);
    e.done    = dn;
    q.push_back(e);
  endtask

  task automatic tick(input logic r, input logic [7:0] b, input logic s, input logic p);
    rst = r; btn = b; start = s; stop = p;
    @(posedge clk);
    model(r, b, s, p);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("note_req", 32'(note_req), 32'(mon_e.note));
      chk("playing",  32'(playing),  32'(mon_e.playing));
      chk("step_idx", 32'(step_idx), 32'(mon_e.step));
      chk("done",     32'(done),     32'(mon_e.done));
      if (done === 1'b1) done_seen++;
    end
  end

  initial begin
    int mark;
    int burst;
    logic [7:0] bval;
    build_timeline();

    // Reset with a key held, then release
    repeat (3) tick(1'b0, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    run(2);

    // Start, press two keys during step1, let the rest entry play, then stop+start
    tick(1'b1, 8'h00, 1'b1, 1'b0);
    run(120);
    repeat (30) tick(1'b1, 8'h24, 1'b0, 1'b0);
    run(400);
    tick(1'b1, 8'h00, 1'b1, 1'b1);
    run(5);
    tick(1'b1, 8'h00, 1'b1, 1'b1);
    run(3);

    // Full run with a stray start mid-song
    @(negedge clk); #1;
    mark = done_seen;
    tick(1'b1, 8'h00, 1'b1, 1'b0);
    run(300);
    tick(1'b1, 8'h00, 1'b1, 1'b0);
    run(2220);
    @(negedge clk); #1;
    chk("done_pulses", 32'(done_seen - mark), 32'd1);
    tick(1'b1, 8'h00, 1'b0, 1'b1);
    run(2);

    // Randomized keypad bursts with occasional start/stop
    burst = 0;
    bval = 8'h00;
    for (int i = 0; i < 6000; i++) begin
      logic s, p;
      if (burst == 0 && $urandom_range(59, 0) == 0) begin
        burst = $urandom_range(40, 1);
        bval  = 8'($urandom_range(255, 1));
      end
      s = ($urandom_range(199, 0) == 0);
      p = ($urandom_range(799, 0) == 0);
      tick(1'b1, (burst > 0) ? bval : 8'h00, s, p);
      if (burst > 0) burst--;
    end
    tick(1'b1, 8'h00, 1'b0, 1'b1);
    run(2);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
